// File: rtl/snn_step_controller.sv
// Time-step sequencer for the neuron core: collects input spikes, issues one
// synapse-row update per spike, then sweeps every neuron through leak/fire.
module snn_step_controller #(
    parameter int NR_DEPTH   = 16,
    parameter int SR_DEPTH   = 16384,
    parameter int TIME_W     = 16,
    parameter int MAX_SPIKES = 64,
    parameter int NUM_AXONS  = SR_DEPTH / NR_DEPTH,
    parameter int AXON_W     = $clog2(NUM_AXONS),
    parameter int NEURON_W   = $clog2(NR_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                free_run,
    input  logic [TIME_W-1:0]   num_steps,
    input  logic                host_pause,
    input  logic                spk_valid,
    input  logic [AXON_W-1:0]   spk_axon,
    input  logic                spk_last,
    output logic                spk_ready,
    output logic                upd_valid,
    output logic [AXON_W-1:0]   upd_axon,
    input  logic                upd_ready,
    output logic                fire_valid,
    output logic [NEURON_W-1:0] fire_neuron,
    input  logic                fire_ready,
    output logic                freeze,
    output logic [AXON_W-1:0]   spike_index,
    output logic [TIME_W-1:0]   time_index,
    output logic                step_done,
    output logic                run_done,
    output logic                overflow
);

    localparam int CNT_W = $clog2(MAX_SPIKES + 1);

    typedef enum logic [2:0] {IDLE, COLLECT, ISSUE, SWEEP, STEP_END, PAUSE} state_t;

    state_t             state;
    logic [TIME_W-1:0]  steps_left;
    logic [CNT_W-1:0]   spike_count;
    logic               last_seen;

    // Every output is a register updated alongside the state transition that
    // enters the state it belongs to, so outputs never glitch mid-cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            steps_left  <= '0;
            spike_count <= '0;
            last_seen   <= 1'b0;
            spk_ready   <= 1'b0;
            upd_valid   <= 1'b0;
            upd_axon    <= '0;
            fire_valid  <= 1'b0;
            fire_neuron <= '0;
            freeze      <= 1'b0;
            spike_index <= '0;
            time_index  <= '0;
            step_done   <= 1'b0;
            run_done    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            step_done <= 1'b0;
            run_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        overflow    <= 1'b0;
                        steps_left  <= (free_run && num_steps != '0) ? num_steps : TIME_W'(1);
                        spike_count <= '0;
                        last_seen   <= 1'b0;
                        freeze      <= 1'b1;
                        spk_ready   <= 1'b1;
                        state       <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (spk_valid) begin
                        // Past the per-step budget the spike is swallowed, but a
                        // final spike must still close the step.
                        if (spike_count == CNT_W'(MAX_SPIKES)) begin
                            overflow <= 1'b1;
                            if (spk_last) begin
                                spk_ready   <= 1'b0;
                                fire_valid  <= 1'b1;
                                fire_neuron <= '0;
                                state       <= SWEEP;
                            end
                        end else begin
                            spike_count <= spike_count + 1'b1;
                            upd_axon    <= spk_axon;
                            spike_index <= spk_axon;
                            last_seen   <= spk_last;
                            upd_valid   <= 1'b1;
                            spk_ready   <= 1'b0;
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (upd_ready) begin
                        upd_valid <= 1'b0;
                        if (last_seen) begin
                            fire_valid  <= 1'b1;
                            fire_neuron <= '0;
                            state       <= SWEEP;
                        end else begin
                            spk_ready <= 1'b1;
                            state     <= COLLECT;
                        end
                    end
                end
                SWEEP: begin
                    if (fire_ready) begin
                        if (fire_neuron == NEURON_W'(NR_DEPTH - 1)) begin
                            fire_valid  <= 1'b0;
                            fire_neuron <= '0;
                            step_done   <= 1'b1;
                            run_done    <= (steps_left == TIME_W'(1));
                            time_index  <= time_index + 1'b1;
                            steps_left  <= steps_left - 1'b1;
                            spike_count <= '0;
                            last_seen   <= 1'b0;
                            state       <= STEP_END;
                        end else begin
                            fire_neuron <= fire_neuron + 1'b1;
                        end
                    end
                end
                STEP_END: begin
                    if (steps_left == '0) begin
                        freeze <= 1'b0;
                        state  <= IDLE;
                    end else if (host_pause) begin
                        freeze <= 1'b0;
                        state  <= PAUSE;
                    end else begin
                        spk_ready <= 1'b1;
                        state     <= COLLECT;
                    end
                end
                PAUSE: begin
                    if (!host_pause) begin
                        freeze    <= 1'b1;
                        spk_ready <= 1'b1;
                        state     <= COLLECT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/snn_step_controller.md
Name: snn_step_controller

Overview:
- Parametrised time-step sequencer for the neuron core; next generation of the top-level controller.
- Per time step: drains the input-spike stream, issues one synapse-row update request per spike to the neuron input module, then sweeps all neurons through the leak/fire phase.
- Drives freeze, spike_index and time_index as real sequenced outputs.
- Supports single-step and free-run modes, host pause, and a per-step spike overflow guard.

Parameters:
- NR_DEPTH, 16, number of neurons, one per NR row.
- SR_DEPTH, 16384, synapse rows; NUM_AXONS = SR_DEPTH/NR_DEPTH; AXON_W = $clog2(NUM_AXONS).
- NEURON_W, $clog2(NR_DEPTH), neuron index width.
- TIME_W, 16, time_index width.
- MAX_SPIKES, 64, maximum accepted spikes per step; excess spikes are dropped.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run from IDLE
- free_run  in  1  1: run num_steps steps back-to-back; 0: run one step per start
- num_steps  in  TIME_W  steps in free-run; 0 is treated as 1
- host_pause  in  1  holds the FSM at the next step boundary
- spk_valid  in  1  input spike available
- spk_axon  in  AXON_W  spiking axon index
- spk_last  in  1  qualifies the final spike of the step; valid with spk_valid
- spk_ready  out  1  spike accepted when spk_valid&&spk_ready
- upd_valid  out  1  update request to neuron input module
- upd_axon  out  AXON_W  axon row to integrate
- upd_ready  in  1  updater accepts request
- fire_valid  out  1  leak/fire request for one neuron
- fire_neuron  out  NEURON_W  neuron index
- fire_ready  in  1  neuron update accepts request
- freeze  out  1  high while a step is in progress; host NR/SR writes blocked
- spike_index  out  AXON_W  axon currently being integrated
- time_index  out  TIME_W  completed-step counter
- step_done  out  1  one-cycle pulse at end of each step
- run_done  out  1  one-cycle pulse at end of run
- overflow  out  1  sticky; a spike beyond MAX_SPIKES was dropped; cleared by start

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; time_index 0.
- Reset is sampled only on the clk edge. Reset mid-step aborts immediately: no further requests are issued and the pending valid drops the next cycle.
- States: IDLE, COLLECT, ISSUE, SWEEP, STEP_END, PAUSE.
- IDLE:
  - On start: clear overflow, load steps_left = max(num_steps,1) if free_run else 1, go to COLLECT.
  - start is ignored outside IDLE.
- COLLECT:
  - freeze=1 and spk_ready=1.
  - On an accepted spike, go to ISSUE with upd_axon=spk_axon and spike_index=spk_axon; increment the per-step count.
  - If the accepted spike has spk_last, set last_seen.
  - If the count has reached MAX_SPIKES, the spike is still accepted (spk_ready stays 1), dropped, and overflow is set. No ISSUE occurs. If it has spk_last, go to SWEEP.
- ISSUE:
  - upd_valid=1 and spk_ready=0.
  - upd_valid and upd_axon stay stable until upd_ready.
  - On handshake: go to SWEEP if last_seen, else COLLECT.
- A step with zero spikes needs spk_valid&&spk_last carrying a dummy axon. Such a spike is still issued; an empty-step flag is outside scope.
- SWEEP:
  - fire_valid=1, fire_neuron counts 0..NR_DEPTH-1, advancing on each fire_ready handshake.
  - After the handshake with index NR_DEPTH-1, go to STEP_END.
  - fire_neuron is stable while waiting.
- STEP_END (1 cycle):
  - step_done=1; time_index+=1, wrapping at 2^TIME_W; decrement steps_left; reset the per-step count.
  - steps_left becomes 0: run_done=1, freeze=0 next cycle, go to IDLE.
  - Otherwise: go to PAUSE if host_pause, else COLLECT.
- PAUSE: freeze=0; no requests issued; return to COLLECT when host_pause=0.
- host_pause has no effect except at STEP_END/PAUSE.
- freeze=1 in COLLECT, ISSUE, SWEEP and STEP_END; 0 in IDLE and PAUSE.
- upd_valid and fire_valid are never high in the same cycle.
- Latency: an accepted spike yields upd_valid on the next cycle. Best-case step cost = 2 cycles per spike + NR_DEPTH + 1.

Test Plan:
- Reset low 3 cycles mid-SWEEP -> all outputs 0 next cycle; IDLE; time_index 0.
- Single step: free_run=0, start, spikes axons 5, 17, 1023(last), upd_ready=fire_ready=1 -> upd_axon sequence 5, 17, 1023; fire_neuron 0..15; step_done once; time_index=1; run_done same cycle as step_done.
- Backpressure: upd_ready low 4 cycles on axon 17 -> upd_valid/upd_axon held at 17; spk_ready=0 throughout.
- Free run: num_steps=3, 1 spike per step, host_pause raised during step 1 -> PAUSE after step 1 with freeze=0; release -> steps 2,3 complete; time_index=3; one run_done.
- Overflow: MAX_SPIKES=64, send 70 spikes -> exactly 64 upd handshakes; overflow=1; sweep runs; next start clears overflow.
- num_steps=0 in free-run -> exactly one step; time_index wrap test from 0xFFFF -> 0x0000.
